// File: rtl/demux8_sched.sv
// Sequencing controller for a 1-to-8 demux: one-entry hold register, round-robin or addressed steering.
// Optional feature: define DEMUX8_SKIP_BUSY_EN so round-robin capture skips channels that are not ready.
module demux8_sched #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [2:0]        in_dest,
  output logic [DATA_W-1:0] out_data,
  output logic [7:0]        out_valid,
  input  logic [7:0]        out_ready,
  output logic [2:0]        sel,
  output logic [CNT_W-1:0]  xfer_cnt,
  output logic              fsm_state
);

  // Handshake: a word moves on any edge where valid and ready are both high;
  // the producer keeps valid/data stable until then, and ready never depends on valid.
  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t     state, state_next;
  logic [2:0] rr_ptr;
  logic [2:0] rr_choice;
  logic       held_mode;
  logic       accept;
  logic       deliver;

  assign fsm_state = state;

`ifdef DEMUX8_SKIP_BUSY_EN
  logic [2:0] idx;
  logic       found;
  always_comb begin
    rr_choice = rr_ptr;
    idx       = 3'd0;
    found     = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = rr_ptr + 3'(i);
      if (!found && out_ready[idx]) begin
        rr_choice = idx;
        found     = 1'b1;
      end
    end
  end
`else
  always_comb begin
    rr_choice = rr_ptr;
  end
`endif

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 8'd0;
    accept     = 1'b0;
    deliver    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid) state_next = SEND;
      end
      SEND: begin
        out_valid = 8'b1 << sel;
        deliver   = out_ready[sel];
        if (out_ready[sel]) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= 3'd0;
      sel       <= 3'd0;
      out_data  <= '0;
      held_mode <= 1'b0;
      xfer_cnt  <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        out_data  <= in_data;
        sel       <= mode ? in_dest : rr_choice;
        held_mode <= mode;
      end
      if (deliver) begin
        xfer_cnt <= xfer_cnt + 1'b1;
        // Only round-robin deliveries move the pointer; held_mode isolates later mode changes.
        if (!held_mode) rr_ptr <= sel + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_demux8_sched.sv
// Directed self-checking bench for demux8_sched (counter width reduced to 4 to reach wrap quickly).
module tb_demux8_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mode;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_dest;
  logic [7:0] out_data;
  logic [7:0] out_valid;
  logic [7:0] out_ready;
  logic [2:0] sel;
  logic [3:0] xfer_cnt;
  logic       fsm_state;

  int         checks = 0;
  int         failures = 0;
  logic [3:0] exp_cnt = 4'd0;

  demux8_sched #(.DATA_W(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_dest(in_dest), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .sel(sel), .xfer_cnt(xfer_cnt), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Accept one word, confirm it is offered on channel ch, and let it deliver (out_ready[ch] must be 1).
  task automatic send_word(input logic [7:0] d, input logic [2:0] dest, input logic md,
                           input logic [2:0] ch);
    check("pre_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_data = d; in_dest = dest; mode = md;
    tick();
    in_valid = 1'b0;
    in_data  = 8'($urandom_range(0, 255));
    in_dest  = 3'($urandom_range(0, 7));
    check("send_out_valid", 32'(out_valid), 32'(8'b1 << ch));
    check("send_out_data", 32'(out_data), 32'(d));
    check("send_sel", 32'(sel), 32'(ch));
    check("send_in_ready", 32'(in_ready), 32'd0);
    check("send_state", 32'(fsm_state), 32'd1);
    tick();
    exp_cnt = exp_cnt + 4'd1;
    check("done_out_valid", 32'(out_valid), 32'd0);
    check("done_in_ready", 32'(in_ready), 32'd1);
    check("done_xfer_cnt", 32'(xfer_cnt), 32'(exp_cnt));
  endtask

  initial begin
    rst_n = 1'b0; mode = 1'b0; in_valid = 1'b0; in_data = 8'd0; in_dest = 3'd0;
    out_ready = 8'hFF;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_xfer_cnt", 32'(xfer_cnt), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    tick();
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Round-robin sweep of all eight channels.
    for (int i = 0; i < 8; i++) send_word(8'h10 + 8'(i), 3'd7, 1'b0, 3'(i));
    check("rr_sweep_cnt", 32'(xfer_cnt), 32'd8);

    // Addressed words, then RR resumes at channel 0 (pointer wrapped and untouched).
    send_word(8'hA5, 3'd5, 1'b1, 3'd5);
    send_word(8'h3C, 3'd2, 1'b1, 3'd2);
    send_word(8'h77, 3'd6, 1'b0, 3'd0);

    // Stalled channel 3; mode flips mid-hold and must not move the RR pointer.
    out_ready = 8'hF7;
    in_valid = 1'b1; in_data = 8'h55; in_dest = 3'd3; mode = 1'b1;
    tick();
    in_valid = 1'b0; mode = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stall_out_valid", 32'(out_valid), 32'h08);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_out_data", 32'(out_data), 32'h55);
      check("stall_cnt", 32'(xfer_cnt), 32'(exp_cnt));
      tick();
    end
    out_ready = 8'hFF;
    tick();
    exp_cnt = exp_cnt + 4'd1;
    check("stall_done_valid", 32'(out_valid), 32'd0);
    check("stall_done_cnt", 32'(xfer_cnt), 32'd12);
    send_word(8'h81, 3'd0, 1'b0, 3'd1);

    // Reset during SEND drops the held word.
    out_ready = 8'h00;
    in_valid = 1'b1; in_data = 8'h9E; in_dest = 3'd6; mode = 1'b1;
    tick();
    in_valid = 1'b0;
    check("pre_rst_valid", 32'(out_valid), 32'h40);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_xfer_cnt", 32'(xfer_cnt), 32'd0);
    check("midrst_out_data", 32'(out_data), 32'd0);
    exp_cnt = 4'd0;
    @(negedge clk); rst_n = 1'b1;
    tick();
    out_ready = 8'hFF;
    send_word(8'h01, 3'd7, 1'b0, 3'd0);
    send_word(8'h02, 3'd7, 1'b0, 3'd1);

    // rr_ptr is now 2, channels 2..4 busy.
    out_ready = 8'b1110_0011;
`ifdef DEMUX8_SKIP_BUSY_EN
    send_word(8'h5A, 3'd0, 1'b0, 3'd5);
    out_ready = 8'hFF;
    send_word(8'h5B, 3'd0, 1'b0, 3'd6);
`else
    in_valid = 1'b1; in_data = 8'h5A; in_dest = 3'd0; mode = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("busy_wait_valid", 32'(out_valid), 32'h04);
      tick();
    end
    out_ready = 8'hFF;
    tick();
    exp_cnt = exp_cnt + 4'd1;
    check("busy_done_cnt", 32'(xfer_cnt), 32'd3);
    send_word(8'h5B, 3'd0, 1'b0, 3'd3);
`endif
    check("pre_wrap_cnt", 32'(xfer_cnt), 32'd4);

    // Counter wrap at 2^4-1.
    for (int i = 0; i < 11; i++) send_word(8'(i), 3'(i), 1'b1, 3'(i));
    check("cnt_at_max", 32'(xfer_cnt), 32'd15);
    send_word(8'hEE, 3'd4, 1'b1, 3'd4);
    check("cnt_wrapped", 32'(xfer_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
